// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin Wishbone arbiter: one registered arbitration cycle, then zero-latency muxing to the owner.
// The owner keeps the bus for its whole cyc, and the other master waits. A stalled strobe gets err after TIMEOUT+1 cycles.
module wb_rr_arbiter2 #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [31:0]           m0_dat_i,
   output logic [31:0]           m0_dat_o,
   input  logic                  m0_we_i,
   input  logic [3:0]            m0_sel_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [31:0]           m1_dat_i,
   output logic [31:0]           m1_dat_o,
   input  logic                  m1_we_i,
   input  logic [3:0]            m1_sel_i,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [31:0]           s_dat_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   input  logic [31:0]           s_dat_i,
   input  logic                  s_ack_i,
   output logic [1:0]            gnt_o
);

   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           last_q, last_d;
   logic [WDW-1:0] wdog_q, wdog_d;

   logic req0, req1;
   logic own_stb;
   logic stall;
   logic wd_fire;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   always_comb begin
      own_stb = 1'b0;
      case (state_q)
         GNT0:    own_stb = m0_stb_i;
         GNT1:    own_stb = m1_stb_i;
         default: own_stb = 1'b0;
      endcase
   end

   assign stall   = own_stb & ~s_ack_i;
   assign wd_fire = (TIMEOUT > 0) && stall && (wdog_q == WDW'(TIMEOUT));

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      wdog_d   = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state_q)
         IDLE: begin
            // last_q names the previous owner, so a tie goes to the other one
            if (req0 && (!req1 || last_q)) begin
               state_d = GNT0;
               last_d  = 1'b0;
            end else if (req1) begin
               state_d = GNT1;
               last_d  = 1'b1;
            end
         end
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_cyc_o  = m0_cyc_i & ~wd_fire;
            s_stb_o  = m0_stb_i & ~wd_fire;
            m0_ack_o = s_ack_i & ~wd_fire;
            m0_err_o = wd_fire;
            if ((TIMEOUT > 0) && stall && !wd_fire) wdog_d = wdog_q + 1'b1;
            if (!m0_cyc_i || wd_fire) state_d = IDLE;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_cyc_o  = m1_cyc_i & ~wd_fire;
            s_stb_o  = m1_stb_i & ~wd_fire;
            m1_ack_o = s_ack_i & ~wd_fire;
            m1_err_o = wd_fire;
            if ((TIMEOUT > 0) && stall && !wd_fire) wdog_d = wdog_q + 1'b1;
            if (!m1_cyc_i || wd_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign gnt_o    = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Directed vector bench for wb_rr_arbiter2 (TIMEOUT=4): one table row per clock cycle,
// and the expected outputs for each row hold during that cycle, before its closing edge.
module tb_wb_rr_arbiter2;

   localparam logic [31:0] A0   = 32'h0000_0010;
   localparam logic [31:0] A14  = 32'h0000_0014;
   localparam logic [31:0] A20  = 32'h0000_0020;
   localparam logic [31:0] W0   = 32'h0400_0000;
   localparam logic [31:0] W1   = 32'h0400_0004;
   localparam logic [31:0] W2   = 32'h0400_0008;
   localparam logic [31:0] D0   = 32'hA5A5_A5A5;
   localparam logic [31:0] D1   = 32'hB1B1_B1B1;
   localparam logic [3:0]  SEL0 = 4'h3;
   localparam logic [3:0]  SEL1 = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_adr, m1_adr, m0_dat_o, m1_dat_o;
   logic        m0_cyc, m0_stb, m1_cyc, m1_stb, m1_we;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] s_adr, s_dat_o, s_dat_i;
   logic        s_we, s_cyc, s_stb, s_ack;
   logic [3:0]  s_sel;
   logic [1:0]  gnt;

   always #5 clk = ~clk;

   wb_rr_arbiter2 #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
      .wb_clk_i(clk),      .wb_rst_i(rst),
      .m0_adr_i(m0_adr),   .m0_dat_i(D0),       .m0_dat_o(m0_dat_o),
      .m0_we_i(1'b0),      .m0_sel_i(SEL0),     .m0_cyc_i(m0_cyc),
      .m0_stb_i(m0_stb),   .m0_ack_o(m0_ack),   .m0_err_o(m0_err),
      .m1_adr_i(m1_adr),   .m1_dat_i(D1),       .m1_dat_o(m1_dat_o),
      .m1_we_i(m1_we),     .m1_sel_i(SEL1),     .m1_cyc_i(m1_cyc),
      .m1_stb_i(m1_stb),   .m1_ack_o(m1_ack),   .m1_err_o(m1_err),
      .s_adr_o(s_adr),     .s_dat_o(s_dat_o),   .s_we_o(s_we),
      .s_sel_o(s_sel),     .s_cyc_o(s_cyc),     .s_stb_o(s_stb),
      .s_dat_i(s_dat_i),   .s_ack_i(s_ack),     .gnt_o(gnt)
   );

   typedef struct {
      logic        rst;
      logic        c0, s0;
      logic [31:0] a0;
      logic        c1, s1, w1;
      logic [31:0] a1;
      logic        ack;
      logic [31:0] sd;
      logic [1:0]  gnt;
      logic        scyc, sstb, swe;
      logic [31:0] sadr;
      logic        k0, k1, e0, e1;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   vidx    = 0;

   function automatic vec_t mk(
      input logic rst, input logic c0, input logic s0, input logic [31:0] a0,
      input logic c1, input logic s1, input logic w1, input logic [31:0] a1,
      input logic ack, input logic [31:0] sd, input logic [1:0] g,
      input logic scyc, input logic sstb, input logic swe, input logic [31:0] sadr,
      input logic k0, input logic k1, input logic e0, input logic e1);
      vec_t v;
      v.rst = rst; v.c0 = c0; v.s0 = s0; v.a0 = a0;
      v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1;
      v.ack = ack; v.sd = sd; v.gnt = g;
      v.scyc = scyc; v.sstb = sstb; v.swe = swe; v.sadr = sadr;
      v.k0 = k0; v.k1 = k1; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s at row %0d: got %h, expected %h", nm, vidx, act, exp);
      else
         n_pass++;
   endtask

   task automatic run(input vec_t v);
      logic [31:0] e_dat;
      logic [3:0]  e_sel;
      @(negedge clk);
      rst = v.rst; m0_cyc = v.c0; m0_stb = v.s0; m0_adr = v.a0;
      m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.w1; m1_adr = v.a1;
      s_ack = v.ack; s_dat_i = v.sd;
      #2;
      e_dat = 32'h0;
      e_sel = 4'h0;
      if (v.gnt == 2'b01) begin e_dat = D0; e_sel = SEL0; end
      if (v.gnt == 2'b10) begin e_dat = D1; e_sel = SEL1; end
      chk("gnt_o",    {30'd0, gnt},   {30'd0, v.gnt});
      chk("s_cyc_o",  {31'd0, s_cyc}, {31'd0, v.scyc});
      chk("s_stb_o",  {31'd0, s_stb}, {31'd0, v.sstb});
      chk("s_we_o",   {31'd0, s_we},  {31'd0, v.swe});
      chk("s_adr_o",  s_adr,          v.sadr);
      chk("s_sel_o",  {28'd0, s_sel}, {28'd0, e_sel});
      chk("s_dat_o",  s_dat_o,        e_dat);
      chk("m0_ack_o", {31'd0, m0_ack}, {31'd0, v.k0});
      chk("m1_ack_o", {31'd0, m1_ack}, {31'd0, v.k1});
      chk("m0_err_o", {31'd0, m0_err}, {31'd0, v.e0});
      chk("m1_err_o", {31'd0, m1_err}, {31'd0, v.e1});
      chk("m0_dat_o", m0_dat_o,       v.sd);
      chk("m1_dat_o", m1_dat_o,       v.sd);
      vidx++;
   endtask

   initial begin
      rst = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = A0;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = W0;
      s_ack = 1'b0; s_dat_i = 32'h0;
      @(posedge clk);

      //          rst c0 s0 a0    c1 s1 w1 a1  ack sd            gnt    cyc stb we adr   k0 k1 e0 e1
      tbl.push_back(mk(1, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b01, 1, 1, 0, A0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b01, 1, 1, 0, A0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 1, 32'hDEADBEEF, 2'b01, 1, 1, 0, A0,    1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, A0,  1, 1, 1, W0, 0, 32'h0,        2'b01, 0, 0, 0, A0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b10, 1, 1, 1, W0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 1, 32'h0,        2'b10, 1, 1, 1, W0,    0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W1, 1, 32'h0,        2'b10, 1, 1, 1, W1,    0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W2, 1, 32'h0,        2'b10, 1, 1, 1, W2,    0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  0, 0, 1, W2, 1, 32'h0,        2'b10, 0, 0, 1, W2,    0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  0, 0, 0, W2, 1, 32'hC0FFEE00, 2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A14, 1, 1, 1, W0, 1, 32'h00001234, 2'b01, 1, 1, 0, A14,   1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, A14, 1, 1, 1, W0, 0, 32'h0,        2'b01, 0, 0, 0, A14,   0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, A0,  1, 1, 1, W0, 0, 32'h0,        2'b10, 1, 1, 1, W0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, A0,  1, 1, 1, W0, 1, 32'h5555AAAA, 2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, A0,  0, 0, 1, W0, 0, 32'h0,        2'b10, 0, 0, 1, W0,    0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, A0,  0, 0, 0, W0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));

      foreach (tbl[i]) run(tbl[i]);

      // m1 stalls with no ack: err on the 5th stalled cycle while m0 waits.
      run(mk(0, 0, 0, A0,  1, 1, 1, W1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         run(mk(0, 1, 1, A20, 1, 1, 1, W1, 0, 32'h0, 2'b10, 1, 1, 1, W1, 0, 0, 0, 0));
      run(mk(0, 1, 1, A20, 1, 1, 1, W1, 0, 32'h0, 2'b10, 0, 0, 1, W1,    0, 0, 0, 1));
      run(mk(0, 1, 1, A20, 0, 0, 0, W1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));

      // m0 stalls 4 cycles and is acked on the 5th: just inside the timeout, so no err.
      for (int i = 0; i < 4; i++)
         run(mk(0, 1, 1, A20, 0, 0, 0, W1, 0, 32'h0, 2'b01, 1, 1, 0, A20, 0, 0, 0, 0));
      run(mk(0, 1, 1, A20, 0, 0, 0, W1, 1, 32'h12345678, 2'b01, 1, 1, 0, A20, 1, 0, 0, 0));
      run(mk(0, 0, 0, A20, 0, 0, 0, W1, 0, 32'h0, 2'b01, 0, 0, 0, A20,   0, 0, 0, 0));
      run(mk(0, 0, 0, A20, 0, 0, 0, W1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
